// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit for the HI/LO path: shift-add multiply and
// restoring divide, one bit per cycle, with stall, divide-by-zero and flush support.
module ex_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               op_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div_by_zero_o
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic               op_div;
  logic               neg1;
  logic               neg2;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   opb;

  logic [WIDTH-1:0]   mag1;
  logic [WIDTH-1:0]   mag2;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   div_diff;
  logic [WIDTH-1:0]   step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [2*WIDTH-1:0] final_result;

  assign mag1   = (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign mag2   = (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
  assign busy_o = (state != IDLE);

  // hi/lo hold {product high, multiplier} for multiply and
  // {partial remainder, dividend/quotient} for divide.
  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    trial    = {hi, lo[WIDTH-1]};
    div_diff = trial[WIDTH-1:0] - opb;
    step_hi  = mul_sum[WIDTH:1];
    step_lo  = {mul_sum[0], lo[WIDTH-1:1]};
    if (op_div) begin
      if (trial >= {1'b0, opb}) begin
        step_hi = div_diff;
        step_lo = {lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = trial[WIDTH-1:0];
        step_lo = {lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Sign fixup on the final step; neg flags are already zero for unsigned ops.
  always_comb begin
    prod     = {step_hi, step_lo};
    rem_fix  = neg1 ? -step_hi : step_hi;
    quot_fix = (neg1 ^ neg2) ? -step_lo : step_lo;
    if (op_div) final_result = {rem_fix, quot_fix};
    else        final_result = (neg1 ^ neg2) ? -prod : prod;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      count         <= '0;
      op_div        <= 1'b0;
      neg1          <= 1'b0;
      neg2          <= 1'b0;
      hi            <= '0;
      lo            <= '0;
      opb           <= '0;
      result_o      <= '0;
      ready_o       <= 1'b0;
      div_by_zero_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready_o       <= 1'b0;
          div_by_zero_o <= 1'b0;
          if (start_i && !annul_i) begin
            op_div <= op_i;
            neg1   <= signed_i & opdata1_i[WIDTH-1];
            neg2   <= signed_i & opdata2_i[WIDTH-1];
            count  <= '0;
            if (op_i && (opdata2_i == '0)) begin
              state         <= DONE;
              ready_o       <= 1'b1;
              div_by_zero_o <= 1'b1;
              result_o      <= {opdata1_i, {WIDTH{1'b1}}};
            end else begin
              state <= RUN;
              hi    <= '0;
              lo    <= op_i ? mag1 : mag2;
              opb   <= op_i ? mag2 : mag1;
            end
          end
        end
        RUN: begin
          if (annul_i) begin
            state <= IDLE;
            count <= '0;
          end else begin
            hi <= step_hi;
            lo <= step_lo;
            if (count == CNT_W'(WIDTH - 1)) begin
              state    <= DONE;
              count    <= '0;
              ready_o  <= 1'b1;
              result_o <= final_result;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        DONE: begin
          state         <= IDLE;
          ready_o       <= 1'b0;
          div_by_zero_o <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          ready_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed testbench for ex_muldiv: checks results, latency, busy window,
// divide-by-zero, annul and asynchronous reset, plus a WIDTH=8 instance.
module tb_ex_muldiv;
  logic        clk = 1'b0;
  logic        rst;
  logic        start, op, sgn, annul;
  logic [31:0] a, b;
  logic [63:0] result;
  logic        ready, busy, dbz;

  logic        start8;
  logic [7:0]  a8, b8;
  logic [15:0] result8;
  logic        ready8, busy8, dbz8;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  ex_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op), .signed_i(sgn),
    .opdata1_i(a), .opdata2_i(b), .annul_i(annul),
    .result_o(result), .ready_o(ready), .busy_o(busy), .div_by_zero_o(dbz)
  );

  ex_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start_i(start8), .op_i(1'b0), .signed_i(1'b0),
    .opdata1_i(a8), .opdata2_i(b8), .annul_i(1'b0),
    .result_o(result8), .ready_o(ready8), .busy_o(busy8), .div_by_zero_o(dbz8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the
  // edge that follows the DONE cycle.
  task automatic run_op(input string tag, input logic o, input logic s,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] exp_res, input int exp_lat, input logic exp_dbz);
    int lat;
    int busy_cnt;
    op = o; sgn = s; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    busy_cnt = 0;
    while (!ready && lat < 100) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    if (busy) busy_cnt++;
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_res"}, result, exp_res);
    check({tag, "_dbz"}, {63'b0, dbz}, {63'b0, exp_dbz});
    check({tag, "_busy"}, 64'(busy_cnt), 64'(exp_lat));
    $display("%s op=%0b signed=%0b a=%h b=%h -> result=%h lat=%0d dbz=%0b",
             tag, o, s, x, y, result, lat, dbz);
    @(posedge clk); #1;
    check({tag, "_idle"}, {62'b0, ready, busy}, 64'd0);
  endtask

  initial begin
    int  lat;
    logic saw_ready;
    start = 1'b0; op = 1'b0; sgn = 1'b0; annul = 1'b0; a = '0; b = '0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_result", result, 64'd0);
    check("reset_flags", {61'b0, ready, busy, dbz}, 64'd0);
    check("reset_result8", {48'b0, result8}, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    run_op("multu_max",  1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 33, 1'b0);
    run_op("mult_neg3x7", 1'b0, 1'b1, 32'hFFFFFFFD, 32'd7,       64'hFFFFFFFF_FFFFFFEB, 33, 1'b0);
    run_op("mult_minsq", 1'b0, 1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 33, 1'b0);
    run_op("div_neg7d2", 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 33, 1'b0);
    run_op("div_7dneg2", 1'b1, 1'b1, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, 1'b0);
    run_op("divu_100d7", 1'b1, 1'b0, 32'd100,      32'd7,        64'h00000002_0000000E, 33, 1'b0);
    run_op("div_mindm1", 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33, 1'b0);
    run_op("divu_by0",   1'b1, 1'b0, 32'h00001234, 32'd0,        64'h00001234_FFFFFFFF, 1,  1'b1);

    // Annul in RUN: back to IDLE, no ready pulse, result untouched.
    op = 1'b0; sgn = 1'b0; a = 32'd5; b = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    annul = 1'b1;
    @(posedge clk); #1;
    annul = 1'b0;
    check("annul_busy", {62'b0, busy, ready}, 64'd0);
    check("annul_keep", result, 64'h00001234_FFFFFFFF);
    saw_ready = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (ready || busy) saw_ready = 1'b1;
    end
    check("annul_quiet", {63'b0, saw_ready}, 64'd0);
    $display("annul_run result=%h busy=%0b", result, busy);

    // Start with annul high in IDLE is dropped.
    start = 1'b1; annul = 1'b1;
    @(posedge clk); #1;
    check("annul_idle", {63'b0, busy}, 64'd0);
    start = 1'b0; annul = 1'b0;
    @(posedge clk); #1;
    check("annul_idle2", {63'b0, busy}, 64'd0);
    $display("annul_idle busy=%0b", busy);

    // Asynchronous reset between clock edges mid-RUN.
    op = 1'b0; sgn = 1'b0; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("areset_flags", {61'b0, busy, ready, dbz}, 64'd0);
    check("areset_result", result, 64'd0);
    $display("async_reset busy=%0b result=%h", busy, result);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    run_op("divu_9d3", 1'b1, 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 1'b0);

    // WIDTH=8 instance.
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 1;
    while (!ready8 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w8_lat", 64'(lat), 64'd9);
    check("w8_res", {48'b0, result8}, 64'h0000_0000_0000_FE01);
    check("w8_dbz", {63'b0, dbz8}, 64'd0);
    $display("w8_multu a=%h b=%h -> result=%h lat=%0d busy=%0b", a8, b8, result8, lat, busy8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
